// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Writable instruction memory with a byte-stream loader. Program bytes arrive
// over a valid/ready handshake, are packed into 32-bit little-endian words and
// written sequentially from word address 0. The processor reads the memory
// through the same addr/q port a ROM would present, and is held in reset
// (cpu_reset) while a load session is in progress.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset; clears state and all memory
//   load_start  single-cycle request to begin a load session (IDLE/DONE only)
//   load_len    number of words to load, sampled with load_start, clamped
//   byte_in     program byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader can accept a byte (high only in LOAD)
//   addr        processor read word address
//   q           combinational read data mem[addr]
//   busy        load in progress
//   done        last session completed (sticky until next start or reset)
//   wr_count    words written in the current or last session
//   cpu_reset   reset OR busy, drives the processor reset
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic [$clog2(DEPTH):0]     load_len,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    output logic [N-1:0]               q,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     wr_count,
    output logic                       cpu_reset
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    mem [DEPTH];
    logic [23:0]     word_buf;
    logic [1:0]      byte_idx;
    logic [AW-1:0]   waddr;
    logic [AW:0]     len_reg;
    logic [AW:0]     len_clamped;

    logic            start;
    logic            accept;
    logic            word_wr;
    logic            last_word;

    // A start request is only honoured outside LOAD, so it can never coincide
    // with a byte accept (which needs byte_ready, i.e. LOAD).
    assign start       = load_start && (state != LOAD);
    assign accept      = byte_valid && byte_ready;
    assign word_wr     = accept && (byte_idx == 2'd3);
    assign last_word   = word_wr && ((wr_count + 1'b1) == len_reg);
    assign len_clamped = (load_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : load_len;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length request completes immediately.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_next = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (last_word) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from the state, so done and
    // busy move in the cycle after the completing edge.
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Byte assembly and word writes. Bytes 0..2 are parked in word_buf; the
    // edge that accepts byte 3 writes the full word, so the buffer never holds
    // the top byte. A stalled stream simply leaves the partial word in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= '0;
            waddr    <= '0;
            wr_count <= '0;
            len_reg  <= '0;
            word_buf <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (start) begin
            byte_idx <= '0;
            waddr    <= '0;
            wr_count <= '0;
            len_reg  <= len_clamped;
        end else if (accept) begin
            if (word_wr) begin
                mem[waddr] <= N'({byte_in, word_buf});
                waddr      <= waddr + 1'b1;
                wr_count   <= wr_count + 1'b1;
                byte_idx   <= '0;
            end else begin
                word_buf[{byte_idx, 3'b000} +: 8] <= byte_in;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    assign q         = mem[addr];
    assign cpu_reset = reset | busy;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction memory with a byte-stream loader port: the write-side counterpart of the read-only instruction memory.
- Accepts program bytes over a valid/ready handshake, assembles 32-bit little-endian words and writes them sequentially from word address 0.
- The processor reads it through the same addr/q port the ROM presents.
- Holds the processor in reset while a load is in progress.

Parameters:
- N, 32, instruction word width; only 32 is supported (4 bytes per word).
- DEPTH, 64, number of words; read address width is 6 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- load_start  in  1  single-cycle request to begin a load session
- load_len  in  7  number of words to load; sampled when load_start is accepted
- byte_in  in  8  program byte
- byte_valid  in  1  byte_in holds a valid byte
- byte_ready  out  1  loader can accept a byte
- addr  in  6  processor read word address
- q  out  32  read data, combinational: mem[addr]
- busy  out  1  load in progress
- done  out  1  last session completed; sticky
- wr_count  out  7  words written in the current or last session
- cpu_reset  out  1  reset OR busy; drives processor reset

Behaviour:
- Reset (sync): state IDLE; byte_ready=0, busy=0, done=0, wr_count=0.
  - All DEPTH words cleared to 0.
  - Byte index and write address cleared; any partial word is discarded.
- States:
  - IDLE: byte_ready=0, busy=0.
  - LOAD: byte_ready=1, busy=1, done=0.
  - DONE: byte_ready=0, busy=0, done=1.
- Session start:
  - load_start is accepted in IDLE or DONE. On that edge: wr_count=0, write address=0, byte index=0, len_reg=min(load_len, 64).
  - If load_len=0, go to DONE on the same edge with wr_count=0.
  - Otherwise go to LOAD on the same edge.
- load_start in LOAD is ignored.
- Byte transfer:
  - A byte is accepted on an edge where byte_valid & byte_ready.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k], little-endian.
  - A byte_valid pulse with byte_ready=0 is dropped. No buffering.
- Word write:
  - Happens on the edge that accepts byte 3.
  - On that edge: mem[waddr] = assembled word, waddr++, wr_count++.
  - The new word is visible on q from the next cycle.
- Completion:
  - On the edge that writes word number len_reg, go to DONE.
  - done and busy change in the cycle after that edge; no extra bytes are accepted.
- Throughput: one byte per cycle with byte_valid held high. A session of L words finishes 4L edges after the start edge.
- Gaps in byte_valid stall assembly; the partial word is held indefinitely.
- Reset mid-LOAD has full reset effect; memory is cleared and the session is abandoned.
- The read port works in every state. During LOAD the processor is held in reset via cpu_reset, so reads are don't-care.
- Words beyond len_reg keep their values from reset or from earlier sessions. A new session does not clear memory.
- cpu_reset = reset | busy, combinational.

Test Plan:
1. Basic load:
   - Stimulus: reset; load_start with load_len=1; bytes 05,00,1F,8B back-to-back.
   - Required: done=1 and busy=0 in the cycle after the 4th accept; wr_count=1; addr=0 gives q=0x8B1F0005; addr=1 gives q=0.
2. Throughput:
   - Stimulus: load_len=2 started at edge E; valid held high; bytes 01..08.
   - Required: accepts at edges E+1..E+8; done after E+8; q[0]=0x04030201, q[1]=0x08070605; cpu_reset high exactly while busy.
3. Backpressure:
   - Stimulus: same data as scenario 2 with byte_valid low on alternate cycles.
   - Required: identical memory contents; done after E+16; byte_ready stays 1 throughout LOAD.
4. Reset mid-load:
   - Stimulus: load_len=4; 6 bytes accepted; then reset for 1 cycle.
   - Required: busy=0, byte_ready=0, done=0, wr_count=0; q=0 at addr 0 and 1.
5. Boundaries:
   - load_len=0: done next cycle, wr_count=0, no bytes accepted.
   - load_len=100: clamped to 64; after 256 bytes, wr_count=64 and addr=63 holds the last word.
   - load_start pulsed mid-LOAD: ignored; the session continues.
6. Reload:
   - Stimulus: after a session with load_len=2, start a new one with load_len=1 and data AABBCCDD.
   - Required: done drops on the start edge; q[0]=0xDDCCBBAA; q[1] keeps the old word.
